// File: rtl/bpv_pkg.sv
// Shared definitions for the angle/reflector move sequencer: state encoding,
// source identifiers and the default position width.
package bpv_pkg;

  localparam int unsigned DEF_ANGLE_W = 5;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] STOW   = 3'd1;
  localparam logic [2:0] MOVE   = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] REFL   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam logic SRC_MANUAL = 1'b1;
  localparam logic SRC_AUTO   = 1'b0;

  typedef enum logic [2:0] {
    StIdle   = IDLE,
    StStow   = STOW,
    StMove   = MOVE,
    StSettle = SETTLE,
    StRefl   = REFL,
    StDone   = DONE
  } seq_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by every timed wait in the sequencer.
// expire is high during the last counted cycle, so a load of N acts N edges later.
module seq_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/angle_move_sequencer.sv
// Arbitrates manual/automatic setpoints and sequences reflector stow, slew-limited
// motor stepping, mechanical settle and reflector deploy for one panel axis.
module angle_move_sequencer
  import bpv_pkg::*;
#(
  parameter int unsigned ANGLE_W    = DEF_ANGLE_W,
  parameter int unsigned ANGLE_MAX  = 24,
  parameter int unsigned STEP_DIV   = 16,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned REFL_CYC   = 32
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic               man_valid,
  input  logic [ANGLE_W-1:0] man_angle,
  input  logic               man_refl,
  output logic               man_ready,
  input  logic               auto_valid,
  input  logic [ANGLE_W-1:0] auto_angle,
  input  logic               auto_refl,
  output logic               auto_ready,
  input  logic               abort,
  output logic               motor_step,
  output logic               motor_dir,
  output logic               refl_drive,
  output logic [ANGLE_W-1:0] angle_pos,
  output logic               grant_src,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  localparam int unsigned TmrMax = max3(STEP_DIV, SETTLE_CYC, REFL_CYC);
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  localparam logic [TmrW-1:0]    TmrStep   = TmrW'(STEP_DIV);
  localparam logic [TmrW-1:0]    TmrSettle = TmrW'(SETTLE_CYC);
  localparam logic [TmrW-1:0]    TmrRefl   = TmrW'(REFL_CYC);
  localparam logic [ANGLE_W-1:0] AngleMax  = ANGLE_W'(ANGLE_MAX);

  seq_state_e         state_q;
  logic [ANGLE_W-1:0] angle_pos_q;
  logic [ANGLE_W-1:0] tgt_q;
  logic               tgt_refl_q;
  logic               refl_drive_q;
  logic               refl_wait_q;
  logic               motor_step_q;
  logic               motor_dir_q;
  logic               grant_src_q;
  logic               done_q;
  logic               aborted_q;

  logic               ready;
  logic               accept;
  logic [ANGLE_W-1:0] sel_angle;
  logic [ANGLE_W-1:0] sel_clamp;
  logic               sel_refl;
  logic               need_stow;
  logic               abort_act;
  logic               tmr_load;
  logic [TmrW-1:0]    tmr_val;
  logic               tmr_expire;

  assign ready      = (state_q == StIdle);
  assign man_ready  = ready;
  assign auto_ready = ready & ~man_valid;
  assign accept     = ready & (man_valid | auto_valid);

  // Manual wins whenever it is valid; auto is only selected when manual is idle.
  assign sel_angle = man_valid ? man_angle : auto_angle;
  assign sel_refl  = man_valid ? man_refl : auto_refl;
  assign sel_clamp = (sel_angle > AngleMax) ? AngleMax : sel_angle;
  assign need_stow = refl_drive_q & (sel_clamp != angle_pos_q);
  assign abort_act = abort & (state_q != StIdle);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (abort_act) begin
      tmr_load = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            tmr_load = 1'b1;
            tmr_val  = need_stow ? TmrRefl : TmrStep;
          end
        end
        StStow: begin
          if (tmr_expire) begin
            tmr_load = 1'b1;
            tmr_val  = TmrStep;
          end
        end
        StMove: begin
          if (angle_pos_q == tgt_q) begin
            tmr_load = 1'b1;
            tmr_val  = TmrSettle;
          end else if (tmr_expire) begin
            tmr_load = 1'b1;
            tmr_val  = TmrStep;
          end
        end
        StSettle: begin
          if (tmr_expire && (refl_drive_q != tgt_refl_q)) begin
            tmr_load = 1'b1;
            tmr_val  = TmrRefl;
          end
        end
        default: ;
      endcase
    end
  end

  seq_timer #(
    .CNT_W(TmrW)
  ) u_timer (
    .clk     (clk),
    .res_n   (res_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expire  (tmr_expire)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q      <= StIdle;
      angle_pos_q  <= '0;
      tgt_q        <= '0;
      tgt_refl_q   <= 1'b0;
      refl_drive_q <= 1'b0;
      refl_wait_q  <= 1'b0;
      motor_step_q <= 1'b0;
      motor_dir_q  <= 1'b0;
      grant_src_q  <= SRC_AUTO;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      motor_step_q <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      if (abort_act) begin
        // Position and reflector freeze where they are; no further steps.
        state_q   <= StIdle;
        aborted_q <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              tgt_q       <= sel_clamp;
              tgt_refl_q  <= sel_refl;
              grant_src_q <= man_valid ? SRC_MANUAL : SRC_AUTO;
              refl_wait_q <= 1'b0;
              if (need_stow) begin
                refl_drive_q <= 1'b0;
                state_q      <= StStow;
              end else begin
                state_q <= StMove;
              end
            end
          end
          StStow: begin
            if (tmr_expire) state_q <= StMove;
          end
          StMove: begin
            if (angle_pos_q == tgt_q) begin
              state_q <= StSettle;
            end else if (tmr_expire) begin
              motor_step_q <= 1'b1;
              motor_dir_q  <= (tgt_q > angle_pos_q);
              angle_pos_q  <= (tgt_q > angle_pos_q) ? angle_pos_q + ANGLE_W'(1)
                                                    : angle_pos_q - ANGLE_W'(1);
            end
          end
          StSettle: begin
            if (tmr_expire) begin
              state_q <= StRefl;
              if (refl_drive_q != tgt_refl_q) begin
                refl_drive_q <= tgt_refl_q;
                refl_wait_q  <= 1'b1;
              end
            end
          end
          StRefl: begin
            if (!refl_wait_q || tmr_expire) begin
              state_q     <= StDone;
              done_q      <= 1'b1;
              refl_wait_q <= 1'b0;
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign motor_step = motor_step_q;
  assign motor_dir  = motor_dir_q;
  assign refl_drive = refl_drive_q;
  assign angle_pos  = angle_pos_q;
  assign grant_src  = grant_src_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_angle_move_sequencer.sv
// Scoreboard bench: stimulus queues expected step/reflector/done/abort events with
// their cycle stamps; a negedge monitor pops and compares each event the DUT emits.
module tb_angle_move_sequencer;

  localparam int EvStep  = 0;
  localparam int EvRefl  = 1;
  localparam int EvDone  = 2;
  localparam int EvAbort = 3;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       man_valid = 1'b0;
  logic [4:0] man_angle = '0;
  logic       man_refl = 1'b0;
  logic       man_ready;
  logic       auto_valid = 1'b0;
  logic [4:0] auto_angle = '0;
  logic       auto_refl = 1'b0;
  logic       auto_ready;
  logic       abort = 1'b0;
  logic       motor_step;
  logic       motor_dir;
  logic       refl_drive;
  logic [4:0] angle_pos;
  logic       grant_src;
  logic       busy;
  logic       done;
  logic       aborted;

  angle_move_sequencer #(
    .ANGLE_W   (5),
    .ANGLE_MAX (24),
    .STEP_DIV  (16),
    .SETTLE_CYC(8),
    .REFL_CYC  (32)
  ) dut (
    .clk       (clk),
    .res_n     (res_n),
    .man_valid (man_valid),
    .man_angle (man_angle),
    .man_refl  (man_refl),
    .man_ready (man_ready),
    .auto_valid(auto_valid),
    .auto_angle(auto_angle),
    .auto_refl (auto_refl),
    .auto_ready(auto_ready),
    .abort     (abort),
    .motor_step(motor_step),
    .motor_dir (motor_dir),
    .refl_drive(refl_drive),
    .angle_pos (angle_pos),
    .grant_src (grant_src),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int kind;
    int cyc;
    int pos;
    int dir;
    int refl;
  } ev_t;

  ev_t exp_q[$];
  int  prev_refl = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int pos, input int dir,
                         input int refl);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.pos  = pos;
    e.dir  = dir;
    e.refl = refl;
    exp_q.push_back(e);
  endtask

  // Expected event train for one move accepted on edge a (timings in edges after a).
  task automatic push_move(input int a, input int from, input int to, input int rfrom,
                           input int rto, output int done_cyc);
    int m, l, p, n, rcur;
    bit stow;
    stow = (rfrom == 1) && (to != from);
    m = a;
    if (stow) begin
      push_ev(EvRefl, a, from, 0, 0);
      m = a + 32;
    end
    n = (to > from) ? to - from : from - to;
    p = from;
    l = m;
    for (int k = 1; k <= n; k++) begin
      p = (to > from) ? p + 1 : p - 1;
      l = m + 16 * k;
      push_ev(EvStep, l, p, (to > from) ? 1 : 0, 0);
    end
    rcur = stow ? 0 : rfrom;
    if (rcur != rto) begin
      push_ev(EvRefl, l + 9, to, 0, rto);
      done_cyc = l + 41;
    end else begin
      done_cyc = l + 10;
    end
    push_ev(EvDone, done_cyc, to, 0, rto);
  endtask

  task automatic mon_event(input int kind);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected event: kind=%0d cycle=%0d pos=%0d dir=%0d refl=%0d",
               kind, cyc, angle_pos, motor_dir, refl_drive);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.cyc != cyc || e.pos != int'(angle_pos) ||
        (kind == EvStep && e.dir != int'(motor_dir)) ||
        ((kind == EvRefl || kind == EvDone) && e.refl != int'(refl_drive))) begin
      n_fail++;
      $display("FAIL event: got kind=%0d cycle=%0d pos=%0d dir=%0d refl=%0d, expected kind=%0d cycle=%0d pos=%0d dir=%0d refl=%0d",
               kind, cyc, angle_pos, motor_dir, refl_drive, e.kind, e.cyc, e.pos, e.dir,
               e.refl);
    end
  endtask

  always @(negedge clk) begin
    if (res_n) begin
      if (int'(refl_drive) != prev_refl) mon_event(EvRefl);
      if (motor_step) mon_event(EvStep);
      if (done) mon_event(EvDone);
      if (aborted) mon_event(EvAbort);
    end
    prev_refl = int'(refl_drive);
  end

  task automatic wait_cyc(input int x);
    while (cyc < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0 || busy) begin
      n_fail++;
      $display("FAIL %s: timeout with %0d events pending, busy=%0d", name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic issue(input bit use_man, input int ang, input bit refl, output int a);
    @(negedge clk);
    if (use_man) begin
      man_valid = 1'b1;
      man_angle = 5'(ang);
      man_refl  = refl;
    end else begin
      auto_valid = 1'b1;
      auto_angle = 5'(ang);
      auto_refl  = refl;
    end
    @(posedge clk);
    #1;
    a = cyc;
    man_valid  = 1'b0;
    auto_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, d, d2;

    // Initial reset
    repeat (2) @(negedge clk);
    check("rst man_ready", man_ready, 1);
    check("rst angle_pos", angle_pos, 0);
    check("rst busy", busy, 0);
    @(negedge clk);
    res_n = 1'b1;

    // 0/0 -> auto (3,1): steps at +16/+32/+48, refl up at +57, done at +89
    check("t2 auto_ready idle", auto_ready, 1);
    issue(1'b0, 3, 1'b1, a);
    check("t2 grant auto", grant_src, 0);
    check("t2 busy", busy, 1);
    push_ev(EvStep, a + 16, 1, 1, 0);
    push_ev(EvStep, a + 32, 2, 1, 0);
    push_ev(EvStep, a + 48, 3, 1, 0);
    push_ev(EvRefl, a + 57, 3, 0, 1);
    push_ev(EvDone, a + 89, 3, 0, 1);
    wait_quiet("t2 complete", 200);

    // 3/1 -> (1,1): stow, two down-steps, redeploy
    issue(1'b1, 1, 1'b1, a);
    push_move(a, 3, 1, 1, 1, d);
    wait_quiet("t4 complete", 300);
    check("t4 angle_pos", angle_pos, 1);

    // Manual (10,0) and auto (5,0) together: manual first, held auto after done
    @(negedge clk);
    man_valid  = 1'b1;
    man_angle  = 5'd10;
    man_refl   = 1'b0;
    auto_valid = 1'b1;
    auto_angle = 5'd5;
    auto_refl  = 1'b0;
    #1;
    check("t3 man_ready", man_ready, 1);
    check("t3 auto_ready blocked", auto_ready, 0);
    @(posedge clk);
    #1;
    a = cyc;
    man_valid = 1'b0;
    check("t3 grant manual", grant_src, 1);
    push_move(a, 1, 10, 1, 0, d);
    push_move(d + 2, 10, 5, 0, 0, d2);
    wait_cyc(a + 50);
    check("t3 auto_ready busy", auto_ready, 0);
    wait_cyc(d);
    check("t3 auto_ready at done", auto_ready, 0);
    wait_cyc(d + 2);
    auto_valid = 1'b0;
    check("t3 grant auto", grant_src, 0);
    wait_quiet("t3 complete", 400);
    check("t3 angle_pos", angle_pos, 5);

    // Reset during a manual move after two steps
    issue(1'b1, 20, 1'b0, a);
    push_ev(EvStep, a + 16, 6, 1, 0);
    push_ev(EvStep, a + 32, 7, 1, 0);
    wait_cyc(a + 40);
    @(negedge clk);
    res_n = 1'b0;
    #1;
    check("t1 angle_pos", angle_pos, 0);
    check("t1 motor_step", motor_step, 0);
    check("t1 motor_dir", motor_dir, 0);
    check("t1 refl_drive", refl_drive, 0);
    check("t1 grant_src", grant_src, 0);
    check("t1 busy", busy, 0);
    check("t1 done", done, 0);
    check("t1 aborted", aborted, 0);
    check("t1 man_ready", man_ready, 1);
    check("t1 steps seen", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    res_n = 1'b1;

    // Abort after 2 of 5 steps; abort in IDLE is ignored
    issue(1'b1, 5, 1'b0, a);
    push_ev(EvStep, a + 16, 1, 1, 0);
    push_ev(EvStep, a + 32, 2, 1, 0);
    push_ev(EvAbort, a + 41, 2, 0, 0);
    wait_cyc(a + 40);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("t6 ready after abort", man_ready, 1);
    check("t6 busy after abort", busy, 0);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("t6 idle abort busy", busy, 0);
    check("t6 angle_pos", angle_pos, 2);
    wait_quiet("t6 events", 10);

    @(negedge clk);
    res_n = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    check("t5 start pos", angle_pos, 0);

    // Target 31 clamps to 24
    issue(1'b1, 31, 1'b1, a);
    push_move(a, 0, 24, 0, 1, d);
    wait_quiet("t5 complete", 600);
    check("t5 angle_pos", angle_pos, 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
